// File: rtl/sap2_mini_pkg.sv
// rtl/sap2_mini_pkg.sv - shared widths, opcodes, T-states and datapath selects for sap2_mini
package sap2_mini_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 8;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STA = 4'h3,
        OP_LDB = 4'h4, OP_LDX = 4'h5, OP_JMP = 4'h6, OP_JAN = 4'h7,
        OP_JAZ = 4'h8, OP_JIN = 4'h9, OP_JIZ = 4'hA, OP_JMS = 4'hB,
        OP_NPC = 4'hC, OP_NPD = 4'hD, OP_NPE = 4'hE, OP_REG = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        RG_NOP = 4'h0, RG_CLA = 4'h1, RG_XCH = 4'h2, RG_DEX = 4'h3,
        RG_INX = 4'h4, RG_CMA = 4'h5, RG_CMB = 4'h6, RG_IOR = 4'h7,
        RG_AND = 4'h8, RG_NOR = 4'h9, RG_NAN = 4'hA, RG_XOR = 4'hB,
        RG_BRB = 4'hC, RG_INP = 4'hD, RG_OUT = 4'hE, RG_HLT = 4'hF
    } regop_t;

    // One-hot ring counter, one bit per machine cycle
    typedef enum logic [5:0] {
        T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
        T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000
    } tstate_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_IOR, ALU_AND, ALU_NOR,
        ALU_NAN, ALU_XOR, ALU_CMA, ALU_CMB
    } alu_op_t;

    typedef enum logic [1:0] {BUS_MEM, BUS_PC, BUS_IN, BUS_A} bus_sel_t;
    typedef enum logic [1:0] {A_ALU, A_BUS, A_ZERO, A_X} a_sel_t;
    typedef enum logic [1:0] {X_BUS, X_A, X_DEC, X_INC} x_sel_t;
    typedef enum logic {B_BUS, B_ALU} b_sel_t;

endpackage

// File: rtl/sap2_mini_alu.sv
// rtl/sap2_mini_alu.sv - combinational arithmetic/logic unit for the sap2_mini accumulator
module sap2_mini_alu
    import sap2_mini_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_IOR: y = a | b;
            ALU_AND: y = a & b;
            ALU_NOR: y = ~(a | b);
            ALU_NAN: y = ~(a & b);
            ALU_XOR: y = a ^ b;
            ALU_CMA: y = ~a;
            ALU_CMB: y = ~b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/sap2_mini_cpu.sv
// rtl/sap2_mini_cpu.sv - 12-bit six-cycle accumulator CPU with 256x12 program/data RAM
module sap2_mini_cpu
    import sap2_mini_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              prog,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] areg, breg, xreg, ir;
    logic [DATA_W-1:0] bus, mem_rd, alu_b, alu_y, a_next, b_next, x_next;
    logic [ADDR_W-1:0] pc, mar, r;
    logic              halt, run;

    tstate_t  state, state_next;
    opcode_t  op;
    regop_t   rop;
    alu_op_t  alu_op;
    bus_sel_t bus_sel;
    a_sel_t   a_sel;
    b_sel_t   b_sel;
    x_sel_t   x_sel;
    logic ld_mar_pc, ld_mar_ir, inc_pc, ld_ir, jmp_pc, ret_pc, ld_r;
    logic ld_a, ld_b, ld_x, ld_out, set_halt, mem_we;

    assign op     = opcode_t'(ir[11:8]);
    assign rop    = regop_t'(ir[7:4]);
    assign run    = !prog && !halt;
    assign mem_rd = mem[mar];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= T1;
        else     state <= state_next;
    end

    // Programming pins the counter at T1; halt freezes it where it stands
    always_comb begin
        state_next = state;
        if (prog) begin
            state_next = T1;
        end else if (!halt) begin
            case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                T3:      state_next = T4;
                T4:      state_next = T5;
                T5:      state_next = T6;
                default: state_next = T1;
            endcase
        end
    end

    always_comb begin
        ld_mar_pc = 1'b0; ld_mar_ir = 1'b0; inc_pc = 1'b0; ld_ir = 1'b0;
        jmp_pc    = 1'b0; ret_pc    = 1'b0; ld_r   = 1'b0;
        ld_a      = 1'b0; ld_b      = 1'b0; ld_x   = 1'b0; ld_out = 1'b0;
        set_halt  = 1'b0; mem_we    = 1'b0;
        alu_op = ALU_ADD; bus_sel = BUS_MEM; a_sel = A_ALU; b_sel = B_BUS; x_sel = X_BUS;
        case (state)
            T1: begin bus_sel = BUS_PC; ld_mar_pc = 1'b1; end
            T2: inc_pc = 1'b1;
            T3: ld_ir = 1'b1;
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDB, OP_LDX: ld_mar_ir = 1'b1;
                    OP_JMP: jmp_pc = 1'b1;
                    OP_JAN: jmp_pc = areg[DATA_W-1];
                    OP_JAZ: jmp_pc = (areg == '0);
                    OP_JIN: jmp_pc = xreg[DATA_W-1];
                    OP_JIZ: jmp_pc = (xreg == '0);
                    OP_JMS: begin ld_r = 1'b1; jmp_pc = 1'b1; end
                    OP_REG: begin
                        case (rop)
                            RG_CLA: begin ld_a = 1'b1; a_sel = A_ZERO; end
                            RG_XCH: begin ld_a = 1'b1; a_sel = A_X; ld_x = 1'b1; x_sel = X_A; end
                            RG_DEX: begin ld_x = 1'b1; x_sel = X_DEC; end
                            RG_INX: begin ld_x = 1'b1; x_sel = X_INC; end
                            RG_CMA: begin ld_a = 1'b1; alu_op = ALU_CMA; end
                            RG_CMB: begin ld_b = 1'b1; b_sel = B_ALU; alu_op = ALU_CMB; end
                            RG_IOR: begin ld_a = 1'b1; alu_op = ALU_IOR; end
                            RG_AND: begin ld_a = 1'b1; alu_op = ALU_AND; end
                            RG_NOR: begin ld_a = 1'b1; alu_op = ALU_NOR; end
                            RG_NAN: begin ld_a = 1'b1; alu_op = ALU_NAN; end
                            RG_XOR: begin ld_a = 1'b1; alu_op = ALU_XOR; end
                            RG_BRB: ret_pc = 1'b1;
                            RG_INP: begin bus_sel = BUS_IN; ld_a = 1'b1; a_sel = A_BUS; end
                            RG_OUT: ld_out = 1'b1;
                            RG_HLT: set_halt = 1'b1;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin ld_a = 1'b1; a_sel = A_BUS; end
                    OP_ADD: ld_a = 1'b1;
                    OP_SUB: begin ld_a = 1'b1; alu_op = ALU_SUB; end
                    OP_STA: begin bus_sel = BUS_A; mem_we = 1'b1; end
                    OP_LDB: ld_b = 1'b1;
                    OP_LDX: ld_x = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus_sel)
            BUS_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
            BUS_IN:  bus = i;
            BUS_A:   bus = areg;
            default: bus = mem_rd;
        endcase
    end

    // ADD/SUB take their operand from memory over the bus; logic ops use B
    assign alu_b = (alu_op == ALU_ADD || alu_op == ALU_SUB) ? bus : breg;

    sap2_mini_alu u_alu (
        .a  (areg),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    always_comb begin
        case (a_sel)
            A_BUS:   a_next = bus;
            A_ZERO:  a_next = '0;
            A_X:     a_next = xreg;
            default: a_next = alu_y;
        endcase
        case (x_sel)
            X_A:     x_next = areg;
            X_DEC:   x_next = xreg - DATA_W'(1);
            X_INC:   x_next = xreg + DATA_W'(1);
            default: x_next = bus;
        endcase
        b_next = (b_sel == B_ALU) ? alu_y : bus;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            areg <= '0; breg <= '0; xreg <= '0; ir <= '0;
            pc   <= '0; mar  <= '0; r    <= '0;
            out  <= '0; halt <= 1'b0;
        end else if (run) begin
            if (ld_mar_pc) mar  <= bus[ADDR_W-1:0];
            if (ld_mar_ir) mar  <= ir[ADDR_W-1:0];
            if (inc_pc)    pc   <= pc + ADDR_W'(1);
            if (jmp_pc)    pc   <= ir[ADDR_W-1:0];
            if (ret_pc)    pc   <= r;
            if (ld_r)      r    <= pc;
            if (ld_ir)     ir   <= bus;
            if (ld_a)      areg <= a_next;
            if (ld_b)      breg <= b_next;
            if (ld_x)      xreg <= x_next;
            if (ld_out)    out  <= areg;
            if (set_halt)  halt <= 1'b1;
        end
    end

    // RAM has no reset so programs survive clr; the programming port writes even under clr
    always_ff @(posedge clk) begin
        if (prog)
            mem[a] <= d;
        else if (mem_we && run)
            mem[mar] <= bus;
    end

endmodule

// File: tb/tb_sap2_mini_cpu.sv
// tb/tb_sap2_mini_cpu.sv - self-checking bench for sap2_mini_cpu
module tb_sap2_mini_cpu;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        prog = 1'b0;
    logic [7:0]  a_in = '0;
    logic [11:0] d_in = '0;
    logic [11:0] i_in = '0;
    logic [11:0] out;

    int checks = 0;
    int failures = 0;

    logic [11:0] img [256];
    logic [11:0] outs [$];
    logic [11:0] mon_last = '0;

    logic [11:0] m [256];
    logic [11:0] ma, mb, mx, mout;
    logic [7:0]  mpc, mr;
    bit          mh;

    sap2_mini_cpu dut (
        .clk  (clk),
        .clr  (clr),
        .prog (prog),
        .a    (a_in),
        .d    (d_in),
        .i    (i_in),
        .out  (out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!clr && out !== mon_last) begin
            outs.push_back(out);
            mon_last = out;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Instruction-level reference: each instruction runs to completion in one step
    task automatic model_run(input int n, input logic [11:0] inval);
        logic [11:0] w, t;
        logic [7:0]  ad;
        ma = '0; mb = '0; mx = '0; mout = '0; mpc = '0; mr = '0; mh = 1'b0;
        for (int s = 0; s < n && !mh; s++) begin
            w = m[mpc];
            mpc = mpc + 8'd1;
            ad = w[7:0];
            case (w[11:8])
                4'h0: ma = m[ad];
                4'h1: ma = ma + m[ad];
                4'h2: ma = ma - m[ad];
                4'h3: m[ad] = ma;
                4'h4: mb = m[ad];
                4'h5: mx = m[ad];
                4'h6: mpc = ad;
                4'h7: if (ma[11]) mpc = ad;
                4'h8: if (ma == 12'd0) mpc = ad;
                4'h9: if (mx[11]) mpc = ad;
                4'hA: if (mx == 12'd0) mpc = ad;
                4'hB: begin mr = mpc; mpc = ad; end
                4'hF: begin
                    case (w[7:4])
                        4'h1: ma = 12'd0;
                        4'h2: begin t = ma; ma = mx; mx = t; end
                        4'h3: mx = mx - 12'd1;
                        4'h4: mx = mx + 12'd1;
                        4'h5: ma = ~ma;
                        4'h6: mb = ~mb;
                        4'h7: ma = ma | mb;
                        4'h8: ma = ma & mb;
                        4'h9: ma = ~(ma | mb);
                        4'hA: ma = ~(ma & mb);
                        4'hB: ma = ma ^ mb;
                        4'hC: mpc = mr;
                        4'hD: ma = inval;
                        4'hE: mout = ma;
                        4'hF: mh = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    endtask

    task automatic clear_img();
        for (int k = 0; k < 256; k++) img[k] = 12'h000;
    endtask

    task automatic program_ram(input logic with_clr);
        @(negedge clk);
        clr = with_clr;
        prog = 1'b1;
        for (int k = 0; k < 256; k++) begin
            a_in = k[7:0];
            d_in = img[k];
            @(negedge clk);
        end
        prog = 1'b0;
    endtask

    task automatic start_run(input logic [11:0] inval);
        i_in = inval;
        prog = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        outs.delete();
        mon_last = '0;
        clr = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (dut.halt === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        #1;
        checks++; if (out !== 12'h000) begin failures++; $display("FAIL reset_out got=%h exp=000", out); end
        checks++; if (dut.pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", dut.pc); end
        checks++; if ({dut.areg, dut.breg, dut.xreg} !== 36'h0) begin failures++; $display("FAIL reset_abx got=%h exp=0", {dut.areg, dut.breg, dut.xreg}); end
        checks++; if (dut.halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", dut.halt); end
    endtask

    task automatic test_arith();
        logic [11:0] p [11];
        bit ok;
        p = '{12'h007, 12'h108, 12'h109, 12'h20A, 12'hFE0, 12'hFF0, 12'hFFF,
              12'h001, 12'h002, 12'h003, 12'h004};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b1);
        start_run(12'h000);
        wait_halt(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL arith_halt got=timeout exp=halt"); end
        checks++; if (out !== 12'h002) begin failures++; $display("FAIL arith_out got=%h exp=002", out); end
    endtask

    task automatic test_branch();
        logic [11:0] p [12];
        bit ok;
        p = '{12'hFD0, 12'h409, 12'hF80, 12'h806, 12'h00A, 12'h607, 12'h00B,
              12'hFE0, 12'hFF0, 12'h001, 12'hFFF, 12'h000};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b0);
        start_run(12'h001);
        wait_halt(100, ok);
        checks++; if (!ok || out !== 12'hFFF) begin failures++; $display("FAIL branch_i1 got=%h halt=%b exp=fff", out, ok); end
        start_run(12'h000);
        wait_halt(100, ok);
        checks++; if (!ok || out !== 12'h000) begin failures++; $display("FAIL branch_i0 got=%h halt=%b exp=000", out, ok); end
    endtask

    task automatic test_multiply();
        logic [11:0] p [10];
        bit ok;
        p = '{12'h509, 12'hF10, 12'hF30, 12'h108, 12'hA06, 12'h602, 12'hFE0,
              12'hFF0, 12'h00D, 12'h008};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b0);
        start_run(12'h000);
        wait_halt(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mult_halt got=timeout exp=halt"); end
        checks++; if (out !== 12'h068) begin failures++; $display("FAIL mult_out got=%h exp=068", out); end
    endtask

    task automatic load_alu_prog();
        logic [11:0] p [12];
        p = '{12'h010, 12'h411, 12'hFE0, 12'hF70, 12'hFE0, 12'hF90, 12'hFE0,
              12'hFA0, 12'hFE0, 12'hFB0, 12'hFE0, 12'hFF0};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        img[16] = 12'hFFE;
        img[17] = 12'h001;
        program_ram(1'b0);
    endtask

    task automatic test_alu_seq();
        logic [11:0] e [5];
        bit ok;
        e = '{12'hFFE, 12'hFFF, 12'h000, 12'hFFF, 12'hFFE};
        load_alu_prog();
        start_run(12'h000);
        wait_halt(120, ok);
        checks++; if (!ok || outs.size() != 5) begin failures++; $display("FAIL alu_seq_len got=%0d halt=%b exp=5", outs.size(), ok); end
        foreach (e[k]) begin
            checks++;
            if (k >= outs.size() || outs[k] !== e[k]) begin
                failures++;
                $display("FAIL alu_seq[%0d] got=%h exp=%h", k, (k < outs.size()) ? outs[k] : 12'hxxx, e[k]);
            end
        end
    endtask

    task automatic test_subroutine();
        logic [11:0] p [12];
        bit ok;
        p = '{12'h40B, 12'hB05, 12'hFE0, 12'hF00, 12'h708, 12'hF60, 12'hF70,
              12'hFC0, 12'h00B, 12'hFE0, 12'hFF0, 12'h000};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b0);
        start_run(12'h000);
        wait_halt(150, ok);
        checks++;
        if (!ok || outs.size() != 2 || outs[0] !== 12'hFFF || outs[1] !== 12'h000) begin
            failures++;
            $display("FAIL subroutine got_n=%0d first=%h last=%h halt=%b exp=fff,000",
                     outs.size(), (outs.size() > 0) ? outs[0] : 12'hxxx,
                     (outs.size() > 1) ? outs[1] : 12'hxxx, ok);
        end
    endtask

    task automatic test_pointer();
        logic [11:0] p [8];
        bit ok;
        p = '{12'h004, 12'hF20, 12'hF40, 12'h905, 12'hEFF, 12'hF20, 12'hFE0, 12'hFF0};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b0);
        start_run(12'h000);
        wait_halt(100, ok);
        checks++; if (!ok || out !== 12'hF00) begin failures++; $display("FAIL pointer got=%h halt=%b exp=f00", out, ok); end
    endtask

    task automatic test_inp_sta();
        logic [11:0] p [7];
        bit ok;
        p = '{12'hFD0, 12'h308, 12'hF50, 12'hFE0, 12'h008, 12'hFE0, 12'hFF0};
        clear_img();
        foreach (p[k]) img[k] = p[k];
        program_ram(1'b0);
        start_run(12'h001);
        wait_halt(100, ok);
        checks++;
        if (!ok || outs.size() != 2 || outs[0] !== 12'hFFE || outs[1] !== 12'h001) begin
            failures++;
            $display("FAIL inp_sta got_n=%0d first=%h last=%h halt=%b exp=ffe,001",
                     outs.size(), (outs.size() > 0) ? outs[0] : 12'hxxx,
                     (outs.size() > 1) ? outs[1] : 12'hxxx, ok);
        end
        checks++; if (dut.mem[8] !== 12'h001) begin failures++; $display("FAIL inp_sta_mem got=%h exp=001", dut.mem[8]); end
    endtask

    task automatic test_clr_midrun();
        bit ok;
        int c;
        load_alu_prog();
        start_run(12'h000);
        c = 0;
        while (outs.size() < 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++; if (outs.size() < 2) begin failures++; $display("FAIL clr_mid_progress got=%0d exp=2", outs.size()); end
        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        checks++; if (out !== 12'h000) begin failures++; $display("FAIL clr_mid_out got=%h exp=000", out); end
        checks++; if (dut.pc !== 8'h00 || dut.areg !== 12'h000) begin failures++; $display("FAIL clr_mid_pc got=%h a=%h exp=00,000", dut.pc, dut.areg); end
        start_run(12'h000);
        wait_halt(120, ok);
        checks++;
        if (!ok || outs.size() != 5 || outs[2] !== 12'h000 || outs[4] !== 12'hFFE) begin
            failures++;
            $display("FAIL clr_mid_rerun got_n=%0d halt=%b exp=5 outputs", outs.size(), ok);
        end
    endtask

    task automatic test_random();
        logic [11:0] inval;
        int bad;
        for (int rep = 0; rep < 6; rep++) begin
            for (int k = 0; k < 256; k++) begin
                if ($urandom_range(0, 1) == 1)
                    img[k] = {4'hF, 8'($urandom)};
                else
                    img[k] = 12'($urandom);
                m[k] = img[k];
            end
            inval = 12'($urandom);
            program_ram(1'b0);
            model_run(60, inval);
            start_run(inval);
            repeat (360) @(posedge clk);
            @(negedge clk);
            checks++;
            if (dut.areg !== ma || dut.breg !== mb || dut.xreg !== mx) begin
                failures++;
                $display("FAIL rand%0d_abx got=%h,%h,%h exp=%h,%h,%h", rep, dut.areg, dut.breg, dut.xreg, ma, mb, mx);
            end
            checks++;
            if (dut.pc !== mpc || out !== mout || dut.halt !== mh) begin
                failures++;
                $display("FAIL rand%0d_pc_out got=%h,%h,%b exp=%h,%h,%b", rep, dut.pc, out, dut.halt, mpc, mout, mh);
            end
            bad = 0;
            for (int k = 0; k < 256; k++) if (dut.mem[k] !== m[k]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d_mem got=%0d differing words exp=0", rep, bad); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_multiply();
        test_alu_seq();
        test_subroutine();
        test_pointer();
        test_inp_sta();
        test_clr_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
